// File: rtl/alu_pkg.sv
// Shared constants, opcode values, FSM encoding and request record for the ALU issue path.
`timescale 1ns/1ps
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 3;

  // Opcode values belong to the ALU; the issue stage passes them through untouched.
  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } issue_state_t;

  typedef struct packed {
    logic              chain;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [OP_W-1:0]   op;
  } alu_req_t;

endpackage

// File: rtl/alu_req_fifo.sv
// Show-ahead synchronous request FIFO with occupancy count; DEPTH must be a power of two.
`timescale 1ns/1ps
module alu_req_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the clocked ALU: queues requests, drives one op at a time, holds the result.
// Optional macro ALU_ISSUE_CHAIN_EN lets a request take operand A from the last captured result.
`timescale 1ns/1ps
module alu_issue_ctrl #(
  parameter int DATA_W     = 16,
  parameter int OP_W       = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_in1,
  input  logic [DATA_W-1:0] req_in2,
  input  logic [OP_W-1:0]   req_op,
  input  logic              req_chain,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_z,
  output logic              busy
);

  import alu_pkg::*;

  localparam int CNT_W = $clog2(ALU_LAT + 1);

`ifdef ALU_ISSUE_CHAIN_EN
  localparam int REQ_W = 2*DATA_W + OP_W + 1;
`else
  localparam int REQ_W = 2*DATA_W + OP_W;
`endif

  issue_state_t               state;
  logic [CNT_W-1:0]           cnt;
  logic [REQ_W-1:0]           push_data;
  logic [REQ_W-1:0]           head;
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       pop;
  logic                       head_chain;
  logic [DATA_W-1:0]          head_in1;
  logic [DATA_W-1:0]          head_in2;
  logic [OP_W-1:0]            head_op;

`ifdef ALU_ISSUE_CHAIN_EN
  assign push_data  = {req_chain, req_in1, req_in2, req_op};
  assign head_chain = head[REQ_W-1];
`else
  logic unused_chain;
  assign unused_chain = req_chain;
  assign push_data    = {req_in1, req_in2, req_op};
  assign head_chain   = 1'b0;
`endif

  assign head_in1 = head[2*DATA_W+OP_W-1 -: DATA_W];
  assign head_in2 = head[DATA_W+OP_W-1 -: DATA_W];
  assign head_op  = head[OP_W-1:0];

  assign req_ready = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;

  // Issue happens from IDLE, or from HOLD on the very cycle the held result is accepted.
  assign pop = !fifo_empty &&
               ((state == IDLE) || ((state == HOLD) && rsp_ready));

  alu_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (req_valid),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .count     (unused_fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      alu_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_z     <= 1'b0;
    end else begin
      if (pop) begin
        alu_in1 <= head_chain ? rsp_data : head_in1;
        alu_in2 <= head_in2;
        alu_op  <= head_op;
        cnt     <= CNT_W'(ALU_LAT);
      end
      case (state)
        IDLE: if (pop) state <= WAIT;
        WAIT: begin
          if (cnt == '0) begin
            rsp_data  <= alu_out;
            rsp_z     <= alu_z;
            rsp_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= pop ? WAIT : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a one-cycle behavioural ALU attached to its ALU port.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

  import alu_pkg::*;

  typedef struct {
    alu_req_t          req;
    logic [DATA_W-1:0] exp_data;
    logic              exp_z;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [DATA_W-1:0] req_in1 = '0;
  logic [DATA_W-1:0] req_in2 = '0;
  logic [OP_W-1:0]   req_op = '0;
  logic              req_chain = 1'b0;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_out = '0;
  logic              alu_z = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_z;
  logic              busy;

  int tests = 0;
  int failures = 0;

  alu_issue_ctrl dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .req_op    (req_op),
    .req_chain (req_chain),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_z     (alu_z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_z     (rsp_z),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [DATA_W-1:0] aluModel(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [OP_W-1:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Registered ALU with one edge of latency.
  always @(posedge clock) begin
    alu_out <= aluModel(alu_in1, alu_in2, alu_op);
    alu_z   <= (aluModel(alu_in1, alu_in2, alu_op) == '0);
  end

  function automatic vec_t mkVec(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                 input logic [OP_W-1:0] op, input logic [DATA_W-1:0] d,
                                 input logic z);
    vec_t v;
    v.req.chain = 1'b0;
    v.req.in1   = a;
    v.req.in2   = b;
    v.req.op    = op;
    v.exp_data  = d;
    v.exp_z     = z;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Offer one request; returns 1 time unit after the handshake edge.
  task automatic applyStimulus(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                               input logic [OP_W-1:0] op, input logic chain);
    int guard = 0;
    @(negedge clock);
    req_in1 = a; req_in2 = b; req_op = op; req_chain = chain;
    req_valid = 1'b1;
    while (!req_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (!req_ready) checkOutput("push_timeout_ready", req_ready, 1);
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  // Wait for a response, check it stays put for hold cycles, then accept it.
  task automatic takeResponse(input string name, input logic [DATA_W-1:0] exp_data,
                              input logic exp_z, input int hold, output int latency);
    latency = 0;
    while (!rsp_valid && latency < 60) begin
      @(posedge clock);
      #1 latency++;
    end
    checkOutput({name, "_valid"}, rsp_valid, 1);
    checkOutput({name, "_data"}, rsp_data, exp_data);
    checkOutput({name, "_z"}, rsp_z, exp_z);
    for (int h = 0; h < hold; h++) begin
      @(posedge clock);
      #1;
      checkOutput({name, "_hold_valid"}, rsp_valid, 1);
      checkOutput({name, "_hold_data"}, rsp_data, exp_data);
    end
    @(negedge clock);
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[5];
    vec_t b2b[4];
    int   lat;
    int   seen;

    vecs[0] = mkVec(16'd1,      16'd2,  OP_ADD, 16'd3,      1'b0);
    vecs[1] = mkVec(16'd10,     16'd10, OP_SUB, 16'd0,      1'b1);
    vecs[2] = mkVec(16'd10,     16'd9,  OP_SUB, 16'd1,      1'b0);
    vecs[3] = mkVec(16'hFFFF,   16'd1,  OP_ADD, 16'd0,      1'b1);
    vecs[4] = mkVec(16'h00F0,   16'h0FF0, OP_AND, 16'h00F0, 1'b0);

    b2b[0] = mkVec(16'd3, 16'd4, OP_ADD, 16'd7,  1'b0);
    b2b[1] = mkVec(16'd5, 16'd1, OP_SUB, 16'd4,  1'b0);
    b2b[2] = mkVec(16'd6, 16'd6, OP_ADD, 16'd12, 1'b0);
    b2b[3] = mkVec(16'd9, 16'd2, OP_SUB, 16'd7,  1'b0);

    // Reset state while reset is held and just after release.
    #12;
    checkOutput("rst_alu_in1", alu_in1, 0);
    checkOutput("rst_alu_op", alu_op, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_busy", busy, 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checkOutput("rst_req_ready", req_ready, 1);

    // Single ops: latency, data and zero flag.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].req.in1, vecs[i].req.in2, vecs[i].req.op, 1'b0);
      takeResponse($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_z, 1, lat);
      checkOutput($sformatf("vec%0d_latency", i), lat, 3);
      checkOutput($sformatf("vec%0d_valid_drop", i), rsp_valid, 0);
    end

    // Backpressure: five ops with downstream stalled fill the FIFO behind the held result.
    applyStimulus(16'd20, 16'd100, OP_ADD, 1'b0);
    applyStimulus(16'd10, 16'd3,   OP_SUB, 1'b0);
    applyStimulus(16'd2,  16'd8,   OP_SUB, 1'b0);
    applyStimulus(16'd1,  16'd1,   OP_ADD, 1'b0);
    applyStimulus(16'd10, 16'd9,   OP_SUB, 1'b0);
    checkOutput("full_req_ready", req_ready, 0);
    checkOutput("full_busy", busy, 1);
    @(negedge clock);
    req_in1 = 16'hDEAD; req_in2 = 16'hBEEF; req_op = OP_XOR; req_valid = 1'b1;
    repeat (3) @(negedge clock);
    req_valid = 1'b0;
    #1;
    checkOutput("stall_req_ready", req_ready, 0);
    checkOutput("stall_rsp_data", rsp_data, 120);
    takeResponse("bp0", 16'd120,  1'b0, 2, lat);
    takeResponse("bp1", 16'd7,    1'b0, 2, lat);
    takeResponse("bp2", 16'hFFFA, 1'b0, 2, lat);
    takeResponse("bp3", 16'd2,    1'b0, 2, lat);
    takeResponse("bp4", 16'd1,    1'b0, 2, lat);
    seen = 0;
    repeat (10) begin
      @(posedge clock);
      #1 if (rsp_valid) seen++;
    end
    checkOutput("bp_no_extra_rsp", seen, 0);
    checkOutput("bp_idle_busy", busy, 0);

    // Back-to-back with rsp_ready held high: issues land only on handshake edges.
    rsp_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++)
          applyStimulus(b2b[i].req.in1, b2b[i].req.in2, b2b[i].req.op, 1'b0);
      end
      begin
        logic [2*DATA_W+OP_W-1:0] prev_in;
        logic                     prev_valid;
        logic [DATA_W-1:0]        prev_data;
        logic                     hs;
        logic [DATA_W-1:0]        hs_data;
        int issues = 0;
        int handshakes = 0;
        int last_issue = 0;
        prev_in    = {alu_in1, alu_in2, alu_op};
        prev_valid = rsp_valid;
        prev_data  = rsp_data;
        for (int cyc = 1; cyc <= 25; cyc++) begin
          @(posedge clock);
          hs      = prev_valid && rsp_ready;
          hs_data = prev_data;
          #1;
          if (hs) begin
            if (handshakes < 4)
              checkOutput($sformatf("b2b_rsp%0d", handshakes), hs_data, b2b[handshakes].exp_data);
            handshakes++;
          end
          if ({alu_in1, alu_in2, alu_op} != prev_in) begin
            issues++;
            if (issues > 1) begin
              checkOutput($sformatf("b2b_issue%0d_on_hs", issues), hs, 1);
              checkOutput($sformatf("b2b_issue%0d_gap", issues), cyc - last_issue, 3);
            end
            last_issue = cyc;
          end
          prev_in    = {alu_in1, alu_in2, alu_op};
          prev_valid = rsp_valid;
          prev_data  = rsp_data;
        end
        checkOutput("b2b_issue_count", issues, 4);
        checkOutput("b2b_hs_count", handshakes, 4);
      end
    join
    rsp_ready = 1'b0;

    // Chain bit: operand A from the last result when enabled, ignored otherwise.
`ifdef ALU_ISSUE_CHAIN_EN
    applyStimulus(16'd1, 16'd2, OP_ADD, 1'b0);
    takeResponse("chain_first", 16'd3, 1'b0, 0, lat);
    applyStimulus(16'd100, 16'd4, OP_ADD, 1'b1);
    takeResponse("chain_second", 16'd7, 1'b0, 0, lat);
`else
    applyStimulus(16'd5, 16'd6, OP_ADD, 1'b1);
    takeResponse("chain_ignored", 16'd11, 1'b0, 0, lat);
`endif

    // Asynchronous reset in WAIT with a second op queued: everything is discarded.
    applyStimulus(16'd7, 16'd7, OP_ADD, 1'b0);
    applyStimulus(16'd8, 16'd1, OP_SUB, 1'b0);
    checkOutput("mid_alu_in1_pre", alu_in1, 7);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_alu_in1", alu_in1, 0);
    checkOutput("async_alu_in2", alu_in2, 0);
    checkOutput("async_alu_op", alu_op, 0);
    checkOutput("async_rsp_valid", rsp_valid, 0);
    checkOutput("async_rsp_data", rsp_data, 0);
    checkOutput("async_rsp_z", rsp_z, 0);
    checkOutput("async_busy", busy, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_req_ready", req_ready, 1);
    seen = 0;
    repeat (8) begin
      @(posedge clock);
      #1 if (rsp_valid || busy) seen++;
    end
    checkOutput("post_rst_no_replay", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
